ex313_result_collector: RTL
===========================

# ex313_result_collector

Downstream companion to the 8-bit multiply-add pipeline (g = a*b + c + 0x4E, four clock edges of latency). It tracks which operand issues were real and captures the matching `g` results into a small show-ahead FIFO. Results leave through a valid/ready interface, and an optional running sum is kept. It sits directly after the pipeline's `g` register and is the pipeline's only consumer.

## Interface
Parameters:
- `LATENCY`, default 4: number of rising edges from the operand-sampling edge to the edge at which `g` holds the result; must be ≥1.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: high in the cycle `a`/`b`/`c` are presented to the pipeline.
- `g`, input, 16: pipeline result.
- `flush`, input, 1: synchronous clear of tracking, FIFO and flags.
- `out_valid`, output, 1: FIFO non-empty.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `out_data`, output, 16: FIFO head; valid only while `out_valid` is high.
- `count`, output, log2(DEPTH)+1: current FIFO occupancy.
- `overflow`, output, 1: sticky flag; set when a result is dropped.
- `acc`, output, 24: running sum of accepted results.

## Operation
- **Tag line.** A shift register `vtag[LATENCY-1:0]` runs alongside the pipeline.
  - Each edge: `vtag[0]` <= `in_valid`; `vtag[i]` <= `vtag[i-1]`.
  - `push_req` = `vtag[LATENCY-1]`. On that same edge, `g` is the result for the tagged issue and is sampled.
- **FIFO.** DEPTH×16 register array with write and read pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus `count`.
  - `pop` = `out_valid` & `out_ready`.
  - `push` = `push_req` & (`count` < DEPTH | `pop`). When the FIFO is full, a simultaneous pop frees the slot, so the push is accepted.
  - `push_req` while full with no pop: the result is dropped, `overflow` <= 1, and `count` is unchanged.
  - Push and pop together: `count` is unchanged and both pointers advance.
  - Pop while empty is impossible because `out_valid` is 0.
- **Show-ahead output.** `out_data` = `mem[rd_ptr]` (combinational read). `out_valid` = (`count` != 0).
- **Accumulator.** On each accepted push, `acc` <= `acc` + zero-extended `g`, wrapping modulo 2^24. Dropped results are not added.
- **Flush.** Clears `vtag`, the pointers, `count`, `overflow` and `acc`. Flush has priority over a same-cycle push, pop or `in_valid`; in-flight pipeline results are discarded.
- **Reset, asynchronous.**
  - `vtag`, the pointers, `count`, `overflow` and `acc` go to 0; `out_valid` = 0.
  - `out_data` reads `mem[0]` and is don't-care while `out_valid` = 0. The memory array is not reset.
  - Reset mid-stream loses all queued and in-flight results. The pipeline's own `g` register is not reset; while the tag line is 0 its X or stale value is ignored.

## Timing
- Operands sampled at edge k, with `in_valid` = 1 at edge k. The pipeline holds the result in `g` after edge k+LATENCY-1. This block pushes it at edge k+LATENCY.
- That gives `out_valid` = 1 after edge k+LATENCY when the FIFO was empty: LATENCY+1 edges from operand issue to visible output.
- Pop takes effect at the edge where `out_valid` & `out_ready`; the next entry, or `out_valid` = 0, follows after that edge.
- Sustained throughput is one result per cycle when `out_ready` is held high.
- `overflow` rises after the dropping edge and stays high until reset or flush.

## Configuration
- Macro `EX313_COLLECT_ACC_EN`.
- Defined: the 24-bit accumulator is built and behaves as described.
- Undefined: no accumulator register; the `acc` port stays present and is driven constant 0.
- FIFO, tag line and overflow behaviour are identical either way.

## Test plan
- **Single issue.** Reset, then `in_valid` for one cycle with a=3, b=5, c=2, `out_ready` = 0. Required: `out_valid` rises 5 edges after issue with `out_data` = 0x005F, `count` = 1, and `acc` = 0x00005F (macro on) or 0 (macro off).
- **Back-to-back stream.** Issues (255,255,255), (1,1,0), (0,0,0) on consecutive cycles, `out_ready` = 1. Required: outputs on consecutive cycles 0xFF4E, 0x004F, 0x004E; `count` never exceeds 1; `acc` = 0x00FFEB.
- **Overflow.** `out_ready` = 0, 6 consecutive issues with a=1, b=1, c=0..5 (DEPTH=4). Required: `count` = 4, `overflow` = 1; FIFO holds 0x4F, 0x50, 0x51, 0x52; the last two results are dropped and not added to `acc`.
- **Full with simultaneous pop.** With the FIFO full, assert `out_ready` on the edge where a new result arrives. Required: `count` stays 4, the head advances, the new result is appended at the tail, and `overflow` stays 0.
- **Flush versus in-flight.** Issue 2 operands, then `flush` one cycle later. Required: `count` = 0, `out_valid` never rises, `acc` = 0.
- **Reset mid-operation.** Assert `reset` with 3 entries queued and 2 in flight. Required: `out_valid` = 0 immediately (asynchronous); after release, no stale results ever appear on the output.

Source files
------------

// File: rtl/ex313_result_collector.sv
// Result collector for the multiply-add pipeline: tags real issues, captures g into a show-ahead FIFO.
// Optional running sum of accepted results is built when EX313_COLLECT_ACC_EN is defined.
module ex313_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [15:0]                g,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [23:0]                acc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [LATENCY-1:0] r_vtag;
  logic [15:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_overflow;

  logic w_push_req, w_pop, w_full, w_push;

  assign w_push_req = r_vtag[LATENCY-1];
  assign w_full     = (r_count == C_FULL);
  assign w_pop      = out_valid & out_ready;
  // A pop on a full FIFO frees the slot the incoming result lands in.
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign count      = r_count;
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vtag <= '0;
    end else if (flush) begin
      r_vtag <= '0;
    end else begin
      r_vtag[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) r_vtag[i] <= r_vtag[i-1];
    end
  end

  // Storage is not reset; out_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= g;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

`ifdef EX313_COLLECT_ACC_EN
  logic [23:0] r_acc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_acc <= '0;
    else if (flush)  r_acc <= '0;
    else if (w_push) r_acc <= r_acc + {8'h00, g};
  end
  assign acc = r_acc;
`else
  assign acc = '0;
`endif

endmodule
